dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_pkg.sv | 11 +
 rtl/dmem_responder.sv | 105 ++++++++++
 2 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared constants for the line-memory responder: state encoding and line geometry.
package dmem_responder_pkg;

  localparam int LINE_BITS   = 256;
  localparam int OFFSET_BITS = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

endpackage

// File: rtl/dmem_responder.sv
// Fixed-latency 256-bit line memory answering cache-controller requests.
// One transaction in flight; inputs are sampled once at acceptance only.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int LATENCY = 10,
  parameter int DEPTH   = 512
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 write_i,
  input  logic [31:0]          addr_i,
  input  logic [LINE_BITS-1:0] data_i,
  output logic                 ack_o,
  output logic [LINE_BITS-1:0] data_o,
  output logic                 busy_o
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  // Left without reset so a bench can preload lines before reset releases.
  reg [LINE_BITS-1:0] memory [0:DEPTH-1];

  logic [1:0]           r_state;
  logic [7:0]           r_cnt;
  logic                 r_ack;
  logic [LINE_BITS-1:0] r_rdata;
  logic                 r_write;
  logic [IDX_W-1:0]     r_idx;
  logic [LINE_BITS-1:0] r_wdata;

  logic w_accept;
  logic w_done;
  logic w_unused_addr;

  assign w_accept      = (r_state == ST_IDLE) && enable_i;
  assign w_done        = (r_state == ST_WAIT) && (r_cnt == 8'd0);
  assign w_unused_addr = ^{addr_i[31:OFFSET_BITS+IDX_W], addr_i[OFFSET_BITS-1:0]};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
      r_ack   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ack <= 1'b0;
          if (enable_i) begin
            r_state <= ST_WAIT;
            r_cnt   <= CNT_LOAD;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 8'd0) begin
            r_state <= ST_ACK;
            r_ack   <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        ST_ACK: begin
          r_state <= ST_IDLE;
          r_ack   <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_write <= write_i;
      r_idx   <= addr_i[OFFSET_BITS +: IDX_W];
      r_wdata <= data_i;
    end
  end

  // Read data is captured on the edge entering ACK and is zero otherwise.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rdata <= '0;
    end else if (w_done && !r_write) begin
      r_rdata <= memory[r_idx];
    end else begin
      r_rdata <= '0;
    end
  end

  always @(posedge clk_i) begin
    if (w_done && r_write) begin
      memory[r_idx] <= r_wdata;
    end
  end

  assign ack_o  = r_ack;
  assign data_o = r_rdata;
  assign busy_o = (r_state != ST_IDLE);

endmodule
